// File: rtl/z8_loader_pkg.sv
// Shared widths and FSM state encoding for the z8 program loader.
package z8_loader_pkg;

  localparam int OPCODE_W  = 8;
  localparam int OPERAND_W = 16;
  localparam int INSTR_W   = OPCODE_W + 2 * OPERAND_W;
  localparam int NBYTES    = INSTR_W / 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    RUN,
    DONE,
    ERROR
  } loader_state_t;

endpackage

// File: rtl/z8_word_assembler.sv
// Big-endian byte-to-word assembler with running XOR checksum.
module z8_word_assembler #(
  parameter int INSTR_W = z8_loader_pkg::INSTR_W,
  parameter int NBYTES  = z8_loader_pkg::NBYTES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_i,
  input  logic               byte_valid_i,
  input  logic [7:0]         byte_i,
  output logic               word_ready_o,
  output logic [INSTR_W-1:0] word_o,
  output logic [7:0]         checksum_o
);

  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  // Only the first NBYTES-1 bytes are stored; the final byte is taken live.
  logic [INSTR_W-9:0] shift_q;
  logic [IDX_W-1:0]   idx_q;
  logic [7:0]         chk_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      shift_q <= '0;
      idx_q   <= '0;
      chk_q   <= '0;
    end else if (clear_i) begin
      shift_q <= '0;
      idx_q   <= '0;
      chk_q   <= '0;
    end else if (byte_valid_i) begin
      shift_q <= {shift_q[INSTR_W-17:0], byte_i};
      chk_q   <= chk_q ^ byte_i;
      idx_q   <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end
  end

  assign word_ready_o = byte_valid_i && (idx_q == LAST_IDX);
  assign word_o       = {shift_q, byte_i};
  assign checksum_o   = chk_q;

endmodule

// File: rtl/z8_prog_loader.sv
// Byte-serial boot loader: writes program words, verifies checksum, runs the core until halt.
module z8_prog_loader #(
  parameter int OPCODE_W  = 8,
  parameter int OPERAND_W = 16,
  parameter int ADDR_W    = 8,
  localparam int INSTR_W  = OPCODE_W + 2 * OPERAND_W,
  localparam int NBYTES   = INSTR_W / 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               core_rst,
  input  logic               core_halted,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [ADDR_W-1:0]  word_count
);

  import z8_loader_pkg::*;

  loader_state_t      state_q, state_d;
  logic               in_ready_q, mem_we_q, core_rst_q, busy_q, done_q, error_q;
  logic               run_first_q;
  logic [ADDR_W-1:0]  mem_addr_q, word_count_q;
  logic [INSTR_W-1:0] mem_wdata_q;
  logic [7:0]         n_q;

  logic               accept, count_acc, load_acc, wr_fire, last_word;
  logic               asm_ready;
  logic [INSTR_W-1:0] asm_word;
  logic [7:0]         asm_chk;

  assign accept    = in_valid && in_ready_q;
  assign count_acc = accept && (state_q == IDLE || state_q == DONE);
  assign load_acc  = accept && (state_q == LOAD);
  assign wr_fire   = load_acc && asm_ready;
  assign last_word = (word_count_q == ADDR_W'(n_q) - ADDR_W'(1));

  z8_word_assembler #(
    .INSTR_W (INSTR_W),
    .NBYTES  (NBYTES)
  ) u_asm (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (count_acc),
    .byte_valid_i (load_acc),
    .byte_i       (in_data),
    .word_ready_o (asm_ready),
    .word_o       (asm_word),
    .checksum_o   (asm_chk)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (count_acc) state_d = (in_data == 8'h00) ? CHECK : LOAD;
      LOAD:       if (wr_fire && last_word) state_d = CHECK;
      CHECK:      if (accept) state_d = (in_data == asm_chk) ? RUN : ERROR;
      // The first RUN cycle is the core leaving reset; its halt flag is stale there.
      RUN:        if (!run_first_q && core_halted) state_d = DONE;
      ERROR:      state_d = ERROR;
      default:    state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      core_rst_q   <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      word_count_q <= '0;
      n_q          <= '0;
      run_first_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d inside {IDLE, LOAD, CHECK, DONE});
      core_rst_q  <= !(state_d inside {RUN, DONE});
      busy_q      <= (state_d inside {LOAD, CHECK});
      done_q      <= (state_d == DONE);
      error_q     <= (state_d == ERROR);
      run_first_q <= (state_d == RUN) && (state_q != RUN);
      mem_we_q    <= wr_fire;
      if (count_acc) begin
        n_q          <= in_data;
        word_count_q <= '0;
      end
      if (wr_fire) begin
        mem_addr_q   <= word_count_q;
        mem_wdata_q  <= asm_word;
        word_count_q <= word_count_q + 1'b1;
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign core_rst   = core_rst_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_z8_prog_loader.sv
// Directed bench for z8_prog_loader: load, checksum, run/halt, stall and reset scenarios.
module tb_z8_prog_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [39:0] mem_wdata;
  logic        core_rst;
  logic        core_halted;
  logic        busy;
  logic        done;
  logic        error;
  logic [7:0]  word_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;

  int          wr_cnt = 0;
  logic [7:0]  wr_addr [0:15];
  logic [39:0] wr_data [0:15];
  int          wr_cyc  [0:15];
  int          wr_lacc [0:15];

  always #5 clk = ~clk;

  z8_prog_loader dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .core_rst    (core_rst),
    .core_halted (core_halted),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .word_count  (word_count)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Record every write strobe seen mid-cycle; a stretched strobe shows up as an extra write.
  always @(negedge clk) begin
    if (mem_we) begin
      if (wr_cnt < 16) begin
        wr_addr[wr_cnt] = mem_addr;
        wr_data[wr_cnt] = mem_wdata;
        wr_cyc[wr_cnt]  = cyc;
        wr_lacc[wr_cnt] = last_acc;
      end
      wr_cnt = wr_cnt + 1;
    end
  end

  function automatic logic [7:0] xsum(input logic [7:0] q[$]);
    logic [7:0] x = 8'h00;
    for (int i = 1; i < q.size(); i++) x = x ^ q[i];
    return x;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_timeout in_ready=%0b required 1 (byte %h)", in_ready, b);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 last_acc = cyc;
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // No gap is ever inserted after a word's final byte, so word boundaries stay back-to-back.
  task automatic send_seq(input logic [7:0] q[$], input int max_gap);
    int g;
    for (int i = 0; i < q.size(); i++) begin
      send_byte(q[i]);
      if (max_gap > 0 && (i % 5) != 0 && i < q.size() - 1) begin
        g = $urandom_range(0, max_gap);
        if (g > 0) idle(g - 1);
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_timeout done=%0b required 1", name, done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %0b need 0", in_ready); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %0b need 0", mem_we); end
    checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL rst_mem_addr got %h need 00", mem_addr); end
    checks++; if (mem_wdata !== 40'h0) begin errors++; $display("FAIL rst_mem_wdata got %h need 0", mem_wdata); end
    checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL rst_core_rst got %0b need 1", core_rst); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b need 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %0b need 0", done); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL rst_error got %0b need 0", error); end
    checks++; if (word_count !== 8'h00) begin errors++; $display("FAIL rst_word_count got %h need 00", word_count); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got %0b need 1", in_ready); end
    checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL idle_core_rst got %0b need 1", core_rst); end
  endtask

  task automatic test_good_image();
    logic [7:0] q[$];
    // Data bytes 01 00 00 00 01 FF 00 00 00 00 XOR to FF.
    q = '{8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    wr_cnt = 0;
    core_halted = 1'b0;
    send_byte(q[0]);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL good_busy_load got %0b need 1", busy); end
    send_seq(q[1:$], 0);
    send_byte(8'hFF);
    idle(0);
    checks++; if (wr_cnt !== 2) begin errors++; $display("FAIL good_wr_cnt got %0d need 2", wr_cnt); end
    checks++; if (wr_addr[0] !== 8'h00 || wr_data[0] !== 40'h01_0000_0001) begin errors++; $display("FAIL good_word0 got %h@%h need 0100000001@00", wr_data[0], wr_addr[0]); end
    checks++; if (wr_addr[1] !== 8'h01 || wr_data[1] !== 40'hFF_0000_0000) begin errors++; $display("FAIL good_word1 got %h@%h need ff00000000@01", wr_data[1], wr_addr[1]); end
    checks++; if (wr_cyc[0] !== wr_lacc[0] || wr_cyc[1] !== wr_lacc[1]) begin errors++; $display("FAIL good_wr_latency got %0d/%0d need %0d/%0d", wr_cyc[0], wr_cyc[1], wr_lacc[0], wr_lacc[1]); end
    checks++; if (word_count !== 8'd2) begin errors++; $display("FAIL good_word_count got %0d need 2", word_count); end
    checks++; if (core_rst !== 1'b0) begin errors++; $display("FAIL good_core_rst_release got %0b need 0", core_rst); end
    checks++; if (in_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL good_run_outputs in_ready=%0b busy=%0b need 0 0", in_ready, busy); end
    repeat (9) @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL good_done_early got %0b need 0", done); end
    core_halted = 1'b1;
    wait_done("good");
    checks++; if (core_rst !== 1'b0 || in_ready !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL good_done_outputs core_rst=%0b in_ready=%0b error=%0b need 0 1 0", core_rst, in_ready, error); end
  endtask

  task automatic test_reload_from_done();
    logic [7:0] q[$];
    q = '{8'h01, 8'hAB, 8'h12, 8'h34, 8'h56, 8'h78};
    wr_cnt = 0;
    send_byte(q[0]);
    checks++; if (core_rst !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL reload_count core_rst=%0b done=%0b busy=%0b need 1 0 1", core_rst, done, busy); end
    core_halted = 1'b0;
    send_seq(q[1:$], 0);
    // Halt flag already high on entry to RUN: it must be ignored for one cycle.
    core_halted = 1'b1;
    send_byte(xsum(q));
    idle(0);
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reload_first_run_cycle done=%0b need 0", done); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL reload_done done=%0b need 1", done); end
    checks++; if (wr_cnt !== 1 || wr_addr[0] !== 8'h00 || wr_data[0] !== 40'hAB_1234_5678) begin errors++; $display("FAIL reload_word cnt=%0d got %h@%h need 1 ab12345678@00", wr_cnt, wr_data[0], wr_addr[0]); end
    checks++; if (word_count !== 8'd1) begin errors++; $display("FAIL reload_word_count got %0d need 1", word_count); end
  endtask

  task automatic test_empty_image();
    wr_cnt = 0;
    send_byte(8'h00);
    checks++; if (busy !== 1'b1 || core_rst !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL empty_count busy=%0b core_rst=%0b done=%0b need 1 1 0", busy, core_rst, done); end
    core_halted = 1'b0;
    send_byte(8'h00);
    idle(0);
    checks++; if (core_rst !== 1'b0 || busy !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL empty_run core_rst=%0b busy=%0b error=%0b need 0 0 0", core_rst, busy, error); end
    checks++; if (wr_cnt !== 0 || word_count !== 8'd0) begin errors++; $display("FAIL empty_no_write wr_cnt=%0d word_count=%0d need 0 0", wr_cnt, word_count); end
    core_halted = 1'b1;
    wait_done("empty");
  endtask

  task automatic test_bad_checksum();
    logic [7:0] q[$];
    q = '{8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    pulse_reset();
    core_halted = 1'b0;
    wr_cnt = 0;
    send_seq(q, 0);
    send_byte(8'h00);
    idle(0);
    checks++; if (error !== 1'b1 || core_rst !== 1'b1) begin errors++; $display("FAIL bad_error error=%0b core_rst=%0b need 1 1", error, core_rst); end
    checks++; if (in_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bad_outputs in_ready=%0b busy=%0b need 0 0", in_ready, busy); end
    checks++; if (wr_cnt !== 2) begin errors++; $display("FAIL bad_wr_cnt got %0d need 2", wr_cnt); end
    core_halted = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (6) @(negedge clk);
    in_valid = 1'b0;
    checks++; if (error !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0 || core_rst !== 1'b1) begin errors++; $display("FAIL bad_sticky error=%0b in_ready=%0b done=%0b core_rst=%0b need 1 0 0 1", error, in_ready, done, core_rst); end
    pulse_reset();
    @(negedge clk);
    checks++; if (error !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bad_reset_clears error=%0b in_ready=%0b need 0 1", error, in_ready); end
    core_halted = 1'b0;
  endtask

  task automatic test_stall();
    logic [7:0] q[$];
    logic [39:0] exp [0:2];
    q = '{8'h03, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hC3, 8'h00, 8'hFF, 8'h00, 8'h5A,
          8'h80, 8'h01, 8'h02, 8'h03, 8'h04};
    exp[0] = 40'h12_3456_789A;
    exp[1] = 40'hC3_00FF_005A;
    exp[2] = 40'h80_0102_0304;
    wr_cnt = 0;
    send_seq(q, 3);
    send_byte(xsum(q));
    idle(0);
    checks++; if (wr_cnt !== 3) begin errors++; $display("FAIL stall_wr_cnt got %0d need 3", wr_cnt); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wr_addr[i] !== 8'(i) || wr_data[i] !== exp[i] || wr_cyc[i] !== wr_lacc[i]) begin
        errors++;
        $display("FAIL stall_word%0d got %h@%h cyc %0d need %h@%h cyc %0d", i, wr_data[i], wr_addr[i], wr_cyc[i], exp[i], 8'(i), wr_lacc[i]);
      end
    end
    checks++; if (word_count !== 8'd3 || core_rst !== 1'b0) begin errors++; $display("FAIL stall_run word_count=%0d core_rst=%0b need 3 0", word_count, core_rst); end
  endtask

  task automatic test_reset_midload();
    logic [7:0] q[$];
    q = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};
    wr_cnt = 0;
    pulse_reset();
    core_halted = 1'b0;
    send_seq(q[0:8], 0);
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b0 || mem_we !== 1'b0 || core_rst !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL mid_rst_ctrl in_ready=%0b mem_we=%0b core_rst=%0b busy=%0b need 0 0 1 0", in_ready, mem_we, core_rst, busy); end
    checks++; if (mem_addr !== 8'h00 || mem_wdata !== 40'h0 || word_count !== 8'h00) begin errors++; $display("FAIL mid_rst_data addr=%h wdata=%h word_count=%h need 00 0 00", mem_addr, mem_wdata, word_count); end
    checks++; if (done !== 1'b0 || error !== 1'b0 || wr_cnt !== 1) begin errors++; $display("FAIL mid_rst_flags done=%0b error=%0b wr_cnt=%0d need 0 0 1", done, error, wr_cnt); end
    reset = 1'b1;
    wr_cnt = 0;
    send_seq(q, 0);
    send_byte(xsum(q));
    idle(0);
    checks++; if (wr_cnt !== 2) begin errors++; $display("FAIL mid_reload_wr_cnt got %0d need 2", wr_cnt); end
    checks++; if (wr_addr[0] !== 8'h00 || wr_data[0] !== 40'h11_2233_4455) begin errors++; $display("FAIL mid_reload_word0 got %h@%h need 1122334455@00", wr_data[0], wr_addr[0]); end
    checks++; if (wr_addr[1] !== 8'h01 || wr_data[1] !== 40'h66_7788_99AA) begin errors++; $display("FAIL mid_reload_word1 got %h@%h need 66778899aa@01", wr_data[1], wr_addr[1]); end
    checks++; if (core_rst !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL mid_reload_run core_rst=%0b error=%0b need 0 0", core_rst, error); end
  endtask

  initial begin
    reset       = 1'b0;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    core_halted = 1'b0;
    test_reset();
    test_good_image();
    test_reload_from_done();
    test_empty_image();
    test_bad_checksum();
    test_stall();
    test_reset_midload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
